decorr_sequencer: RTL and testbench

DECORR_SEQUENCER -- requirements
Module: decorr_sequencer

---
 rtl/decorr_sequencer.sv | 136 +++++++++++++
 tb/tb_decorr_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/decorr_sequencer.sv
// decorr_sequencer
//   Counts the ones in an incoming stochastic bitstream over a window of
//   N = 2^L cycles, then regenerates a decorrelated stream of the same
//   length carrying the same number of ones. The regenerated bit for cycle
//   k is 1 iff bit-reverse_L(k) < ones, which spreads the ones evenly
//   across the window (a van der Corput style low-discrepancy sequence).
//
// Parameters
//   width     : maximum window exponent; largest window is 2^width bits
//
// Ports
//   clk       : clock, all state updates on rising edge
//   rst       : asynchronous active-high reset
//   start     : request one count+regenerate job (sampled only in IDLE)
//   win_sel   : requested window exponent, latched when start is accepted
//   abort     : synchronous cancel of the running job
//   in_bit    : input bitstream, sampled during COUNT
//   out_bit   : regenerated bitstream, valid while out_valid=1
//   out_valid : high exactly during REGEN cycles
//   busy      : high during COUNT and REGEN
//   done      : one-cycle pulse after the last REGEN cycle
//   count_out : ones count from the last completed COUNT phase
module decorr_sequencer #(
  parameter int width = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2:0]     win_sel,
  input  logic           abort,
  input  logic           in_bit,
  output logic           out_bit,
  output logic           out_valid,
  output logic           busy,
  output logic           done,
  output logic [width:0] count_out
);

  localparam int LW = $clog2(width + 1);

  typedef enum logic [1:0] {IDLE, COUNT, REGEN, DONE} state_t;

  state_t           state_reg;
  logic [LW-1:0]    l_reg;
  logic [LW-1:0]    l_next;
  logic [LW-1:0]    shift_amt;
  logic [width-1:0] index_reg;
  logic [width-1:0] last_index;
  logic [width-1:0] rev_full;
  logic [width-1:0] rev_index;
  logic [width:0]   ones_reg;
  logic [width:0]   ones_sum;
  logic [width:0]   count_reg;

  // Effective exponent: out-of-range or zero requests select the full window.
  always_comb begin
    l_next = LW'(width);
    if (win_sel != 3'd0 && int'(win_sel) <= width)
      l_next = LW'(win_sel);
  end

  // Distance between the full-width and the active window exponent.
  assign shift_amt  = LW'(width) - l_reg;
  assign last_index = {width{1'b1}} >> shift_amt;

  // Reverse all width bits of the index, then shift right so that only the
  // low L bits take part: since index < 2^L, this equals rev_L(index).
  generate
    for (genvar gi = 0; gi < width; gi++) begin : g_rev
      assign rev_full[gi] = index_reg[width-1-gi];
    end
  endgenerate

  assign rev_index = rev_full >> shift_amt;
  assign ones_sum  = ones_reg + {{width{1'b0}}, in_bit};

  // Outputs decode registered state only; no input reaches them directly.
  assign out_valid = (state_reg == REGEN);
  assign out_bit   = out_valid && ({1'b0, rev_index} < count_reg);
  assign busy      = (state_reg == COUNT) || (state_reg == REGEN);
  assign done      = (state_reg == DONE);
  assign count_out = count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      l_reg     <= LW'(width);
      index_reg <= '0;
      ones_reg  <= '0;
      count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && !abort) begin
            l_reg     <= l_next;
            ones_reg  <= '0;
            index_reg <= '0;
            state_reg <= COUNT;
          end
        end
        COUNT: begin
          // abort wins over phase completion
          if (abort) begin
            state_reg <= IDLE;
          end else begin
            ones_reg <= ones_sum;
            if (index_reg == last_index) begin
              count_reg <= ones_sum;
              index_reg <= '0;
              state_reg <= REGEN;
            end else begin
              index_reg <= index_reg + width'(1);
            end
          end
        end
        REGEN: begin
          if (abort) begin
            state_reg <= IDLE;
          end else if (index_reg == last_index) begin
            index_reg <= '0;
            state_reg <= DONE;
          end else begin
            index_reg <= index_reg + width'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decorr_sequencer.sv
module tb_decorr_sequencer;
  localparam int WIDTH = 5;

  logic           clk;
  logic           rst;
  logic           start;
  logic [2:0]     win_sel;
  logic           abort;
  logic           in_bit;
  logic           out_bit;
  logic           out_valid;
  logic           busy;
  logic           done;
  logic [WIDTH:0] count_out;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  int exp_q[$];

  decorr_sequencer #(.width(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .win_sel   (win_sel),
    .abort     (abort),
    .in_bit    (in_bit),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .count_out (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rev_bits(input int k, input int l);
    int r;
    r = 0;
    for (int b = 0; b < l; b++)
      if (k[b]) r = r | (1 << (l - 1 - b));
    return r;
  endfunction

  // One job: sel, input pattern (bit i used in COUNT cycle i), and the
  // COUNT/REGEN cycle on which abort is raised (-1 for none).
  task automatic run_job(input logic [2:0] sel, input logic [31:0] pat,
                         input int abort_cnt, input int abort_reg);
    int l;
    int n;
    int ones;
    int seen;
    int exp_bit;
    bit aborted;
    l = (sel == 3'd0 || int'(sel) > WIDTH) ? WIDTH : int'(sel);
    n = 1 << l;
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(pat[i]);
    for (int k = 0; k < n; k++) exp_q.push_back((rev_bits(k, l) < ones) ? 1 : 0);
    aborted = 1'b0;
    seen = 0;

    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    start = 1'b1;
    win_sel = sel;
    @(posedge clk);

    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = (i == 1);            // must be ignored while running
      win_sel = 3'($urandom);      // must not disturb the latched window
      in_bit = pat[i];
      abort = (i == abort_cnt);
      chk("count_busy", busy, 1);
      chk("count_valid", out_valid, 0);
      chk("count_bit", out_bit, 0);
      @(posedge clk);
      if (i == abort_cnt) begin
        aborted = 1'b1;
        break;
      end
    end
    start = 1'b0;

    if (!aborted) begin
      exp_count = ones;
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        abort = (k == abort_reg);
        in_bit = 1'($urandom);
        chk("regen_valid", out_valid, 1);
        chk("regen_busy", busy, 1);
        if (k == 0) chk("count_out", count_out, 32'(ones));
        exp_bit = exp_q.pop_front();
        chk($sformatf("regen_bit_k%0d", k), out_bit, 32'(exp_bit));
        seen += int'(out_bit);
        @(posedge clk);
        if (k == abort_reg) begin
          aborted = 1'b1;
          break;
        end
      end
    end

    @(negedge clk);
    abort = 1'b0;
    if (aborted) begin
      chk("abort_valid", out_valid, 0);
      chk("abort_done", done, 0);
      chk("abort_busy", busy, 0);
      chk("abort_count_out", count_out, 32'(exp_count));
      exp_q.delete();
    end else begin
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 0);
      chk("done_valid", out_valid, 0);
      chk("regen_ones_total", 32'(seen), 32'(ones));
      @(posedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    win_sel = 3'd0;
    abort = 1'b0;
    in_bit = 1'b0;
    #1;
    chk("rst_out_bit", out_bit, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count_out", count_out, 0);
    @(negedge clk);
    rst = 1'b0;

    // all ones, 8-bit window
    run_job(3'd3, 32'h0000_00FF, -1, -1);
    // 1,0,1,0 -> out 1,0,1,0
    run_job(3'd2, 32'h0000_0005, -1, -1);
    // full 32-bit window, 13 ones
    run_job(3'd0, 32'hA421_0F0F, -1, -1);
    // all zero, then out-of-range selector means 32-bit window
    run_job(3'd4, 32'h0000_0000, -1, -1);
    run_job(3'd7, $urandom, -1, -1);
    // abort on REGEN cycle 3
    run_job(3'd3, 32'h0000_00B2, -1, 3);
    // abort during COUNT keeps the previous count_out
    run_job(3'd2, 32'h0000_000F, 1, -1);

    // abort in IDLE: no effect, and it blocks a simultaneous start
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    win_sel = 3'd3;
    @(posedge clk);
    @(negedge clk);
    chk("abort_blocks_start", busy, 0);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_count_out", count_out, 32'(exp_count));
    abort = 1'b0;

    // reset in the middle of COUNT clears everything without a clock edge
    @(negedge clk);
    start = 1'b1;
    win_sel = 3'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    in_bit = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_out_bit", out_bit, 0);
    chk("midrst_done", done, 0);
    chk("midrst_count_out", count_out, 0);
    exp_count = 0;
    @(negedge clk);
    rst = 1'b0;
    run_job(3'd1, 32'h0000_0003, -1, -1);
    run_job(3'd2, 32'h0000_0008, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
